// File: rtl/mtime_unit.sv
// Machine timer: 64-bit mtime/mtimecmp with prescaler, timer interrupt
// and a two-state valid/ready register port.
module mtime_unit #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [3:0]  mem_addr,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic [63:0] time_o,
   output logic        timer_irq
);

   typedef enum logic {
      IDLE,
      RESP
   } state_t;

   localparam logic [15:0] DIV_LAST = 16'(PRESCALE - 1);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] div_cnt;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [63:0] mtime_nxt;
   logic [63:0] cmp_nxt;
   logic [31:0] rd_word;
   logic [31:0] wr_word;
   logic        tick;
   logic        accept;
   logic        wr;
   logic        unused_addr;

   assign unused_addr = ^mem_addr[1:0];
   assign tick        = div_cnt == DIV_LAST;
   assign wr          = accept & (|mem_wstrb);
   assign mem_ready   = state == RESP;
   assign time_o      = mtime;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (mem_valid) begin
               accept    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_word = '0;
      unique case (mem_addr[3:2])
         2'd0: rd_word = mtime[31:0];
         2'd1: rd_word = mtime[63:32];
         2'd2: rd_word = mtimecmp[31:0];
         2'd3: rd_word = mtimecmp[63:32];
         default: rd_word = '0;
      endcase
   end

   always_comb begin
      wr_word = '0;
      for (int b = 0; b < 4; b++) begin
         wr_word[8*b +: 8] = mem_wstrb[b] ? mem_wdata[8*b +: 8]
                                          : rd_word[8*b +: 8];
      end
   end

   // a write to either mtime half suppresses that cycle's increment
   always_comb begin
      mtime_nxt = tick ? mtime + 64'd1 : mtime;
      cmp_nxt   = mtimecmp;
      if (wr) begin
         unique case (mem_addr[3:2])
            2'd0: mtime_nxt = {mtime[63:32], wr_word};
            2'd1: mtime_nxt = {wr_word, mtime[31:0]};
            2'd2: cmp_nxt   = {mtimecmp[63:32], wr_word};
            2'd3: cmp_nxt   = {wr_word, mtimecmp[31:0]};
            default: cmp_nxt = mtimecmp;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         div_cnt   <= '0;
         mtime     <= '0;
         mtimecmp  <= '1;
         mem_rdata <= '0;
         timer_irq <= 1'b0;
      end else begin
         state     <= state_nxt;
         div_cnt   <= tick ? 16'd0 : div_cnt + 16'd1;
         mtime     <= mtime_nxt;
         mtimecmp  <= cmp_nxt;
         timer_irq <= mtime >= mtimecmp;
         if (accept) begin
            mem_rdata <= rd_word;
         end
      end
   end

endmodule
